ps2_key_scanner: RTL and testbench
==================================

# ps2_key_scanner

Receives raw PS/2 keyboard frames, checks their framing, decodes make/break scan codes and keeps a per-key "held" bitmap for the two players. It sits directly upstream of `game_controller`, whose 8-bit key input it drives, and replaces the ad-hoc left/right/up/down key outputs with a single registered vector. It runs on the 25 MHz pixel clock domain.

## Interface
- `TIMEOUT`, default 5000: maximum clock cycles allowed between two PS/2 clock falling edges inside one frame (200 µs at 25 MHz).
- `clk`  in  1  system clock (25 MHz).
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `PS2_CLK`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `PS2_DAT`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `oKEY`  out  8  held-key bitmap, with one bit per key:
  - bit 0: right1
  - bit 1: left1
  - bit 2: down1
  - bit 3: up1
  - bit 4: right2
  - bit 5: left2
  - bit 6: down2
  - bit 7: up2
- `oCode`  out  8  last correctly received byte.
- `oCode_valid`  out  1  one-cycle pulse when `oCode` updates.
- `oErr`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input synchronisation.** `PS2_CLK` and `PS2_DAT` each pass through 2 flip-flops. A third flip-flop on the clock path gives a falling-edge strobe `fe`: previous synchronised value 1, current value 0.
- **Receiver state machine.** States are IDLE, RECV and CHECK.
  - IDLE: on `fe` with synchronised data = 0 (start bit), go to RECV with bit count 0. On `fe` with data = 1, stay in IDLE; this is a glitch, and no error is flagged.
  - RECV: on each `fe`, shift data in LSB first. Bits 0-7 are data, bit 8 is odd parity, bit 9 is stop. After the 10th post-start edge, go to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE.
    - Success requires the XOR of the 8 data bits and the parity bit to equal 1, and stop = 1. On success, load `oCode` and pulse `oCode_valid`.
    - On failure, pulse `oErr`, discard the byte and clear both prefix flags.
- **Timeout.** A watchdog counter counts cycles in RECV and is cleared on every `fe`. When it reaches `TIMEOUT`, the machine returns to IDLE, pulses `oErr`, clears the bit count and discards the partial byte. The counter saturates and never wraps.
- **Decoder.** It acts on each `oCode_valid` byte, using flags `ext` and `brk`.
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Neither byte changes `oKEY`.
  - Any other byte is a key code. If it maps to a key, that bit is set when `brk` = 0 and cleared when `brk` = 1. Both flags then clear, whether or not the byte mapped.
  - Mapping with `ext` = 1:
    - 0x74: bit 0
    - 0x6B: bit 1
    - 0x72: bit 2
    - 0x75: bit 3
  - Mapping with `ext` = 0:
    - 0x23 (D): bit 4
    - 0x1C (A): bit 5
    - 0x1B (S): bit 6
    - 0x1D (W): bit 7
  - A code with the wrong `ext` state is ignored. For example, keypad 8 (0x75 without 0xE0) and E0 1D do not change `oKEY`.
  - A repeated make (typematic) leaves the bit set. A break for a key that is not held leaves it cleared.
  - Bits are independent. Any combination may be held at once, including opposite directions.
- **Reset.** Reset clears everything: all outputs, state, counters and flags go to 0. This applies mid-frame as well, and any partial frame is lost.

## Timing
- Latency: let `fe` for the stop bit be asserted in cycle T.
  - CHECK is in cycle T+1, where `oCode` and `oCode_valid` are registered, visible at T+1 / high during T+1.
  - `oKEY` updates at T+2.
- Pin-to-`fe` latency is 3 clk cycles.
- `oCode_valid` and `oErr` never assert in the same cycle. Each pulse is exactly 1 cycle.
- An `fe` arriving in the CHECK cycle is treated as a start-bit candidate in IDLE on the next cycle. No edge is lost, because PS/2 edges are ≥ 1500 clk apart.
- Reset values:
  - `oKEY` = 0x00
  - `oCode` = 0x00
  - `oCode_valid` = 0
  - `oErr` = 0
  - state = IDLE
  - `ext` = `brk` = 0

## Test plan
- **Arrow make/break:** send frames E0 75 at 12.5 kHz. `oKEY` must be 0x08 two cycles after the last stop-edge. Then send E0 F0 75; `oKEY` must return to 0x00.
- **Two players:** send make 1D, E0 6B and 23, then break 1D. Required `oKEY` sequence: 0x80 → 0x82 → 0x92 → 0x12.
- **Parity error:** send 0x1D with even parity. Expect one `oErr` pulse, no `oCode_valid`, and `oKEY` unchanged. The next valid 0x1D must set bit 7.
- **Timeout:** stop the PS/2 clock after 4 data bits for `TIMEOUT` + 10 cycles. Expect `oErr` exactly once and a return to IDLE. A following full 0x1C frame must set bit 5.
- **Ignored codes:** send 75 without E0, E0 1D, and unmapped 0x29. `oKEY` must stay 0x00, with `oCode_valid` pulsed for each byte.
- **Reset mid-frame:** assert `reset_n` = 0 after 5 edges with `oKEY` = 0x08. `oKEY` must be 0x00 immediately (asynchronous). After release, a new E0 72 must give 0x04.

Source files
------------

// File: rtl/ps2_key_scanner.sv
// ps2_key_scanner
//   Receives PS/2 keyboard frames, checks parity/stop/timeout, decodes
//   make/break scan codes (with E0 extension and F0 break prefixes) and
//   keeps a held-key bitmap for two players.
//
// Receiver states:
//   state | meaning
//   IDLE  | waiting for a start bit (PS/2 clock falling edge with data low)
//   RECV  | shifting in 8 data bits, parity and stop; watchdog running
//   CHECK | one-cycle slot where the received byte (or error) is presented
//
// Ports:
//   clk          system clock (25 MHz pixel clock)
//   reset_n      asynchronous active-low reset
//   PS2_CLK      raw PS/2 clock pin (asynchronous)
//   PS2_DAT      raw PS/2 data pin (asynchronous)
//   oKEY[7:0]    held keys {up2,down2,left2,right2,up1,down1,left1,right1}
//   oCode[7:0]   last correctly received byte
//   oCode_valid  one-cycle pulse when oCode updates
//   oErr         one-cycle pulse on parity, stop-bit or timeout error

module ps2_key_scanner #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] oKEY,
    output logic [7:0] oCode,
    output logic       oCode_valid,
    output logic       oErr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rxState_t;

    rxState_t        state, stateNext;
    logic [3:0]      bitCnt, bitCntNext;
    logic [9:0]      shiftReg, shiftNext;
    logic [WD_W-1:0] wdCnt, wdNext;
    logic [7:0]      codeNext;
    logic            validNext, errNext, frameBad;

    logic ps2ClkMeta, ps2ClkSync, ps2ClkPrev;
    logic ps2DatMeta, ps2DatSync;
    logic fe;
    logic [9:0] frameNext;
    logic frameOk;

    logic extFlag, brkFlag;
    logic keyHit;
    logic [2:0] keyIdx;

    // Two-flop synchronisers; third flop on the clock path for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2ClkMeta <= 1'b0;
            ps2ClkSync <= 1'b0;
            ps2ClkPrev <= 1'b0;
            ps2DatMeta <= 1'b0;
            ps2DatSync <= 1'b0;
        end else begin
            ps2ClkMeta <= PS2_CLK;
            ps2ClkSync <= ps2ClkMeta;
            ps2ClkPrev <= ps2ClkSync;
            ps2DatMeta <= PS2_DAT;
            ps2DatSync <= ps2DatMeta;
        end
    end

    assign fe = ps2ClkPrev & ~ps2ClkSync;

    // Frame as it will look once the current bit is shifted in (LSB first).
    // After the stop bit: [7:0] data, [8] parity, [9] stop.
    assign frameNext = {ps2DatSync, shiftReg[9:1]};
    assign frameOk   = (^frameNext[8:0]) & frameNext[9];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bitCnt      <= 4'd0;
            shiftReg    <= 10'd0;
            wdCnt       <= '0;
            oCode       <= 8'h00;
            oCode_valid <= 1'b0;
            oErr        <= 1'b0;
        end else begin
            state       <= stateNext;
            bitCnt      <= bitCntNext;
            shiftReg    <= shiftNext;
            wdCnt       <= wdNext;
            oCode       <= codeNext;
            oCode_valid <= validNext;
            oErr        <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        wdNext     = wdCnt;
        codeNext   = oCode;
        validNext  = 1'b0;
        errNext    = 1'b0;
        frameBad   = 1'b0;
        case (state)
            IDLE, CHECK: begin
                // An edge landing in CHECK is still a start-bit candidate
                stateNext = IDLE;
                if (fe && !ps2DatSync) begin
                    stateNext  = RECV;
                    bitCntNext = 4'd0;
                    shiftNext  = 10'd0;
                    wdNext     = WD_LOAD;
                end
            end
            RECV: begin
                if (fe) begin
                    shiftNext = frameNext;
                    wdNext    = WD_LOAD;
                    if (bitCnt == 4'd9) begin
                        stateNext  = CHECK;
                        bitCntNext = 4'd0;
                        if (frameOk) begin
                            validNext = 1'b1;
                            codeNext  = frameNext[7:0];
                        end else begin
                            errNext  = 1'b1;
                            frameBad = 1'b1;
                        end
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end else if (wdCnt == '0) begin
                    stateNext  = IDLE;
                    errNext    = 1'b1;
                    bitCntNext = 4'd0;
                    shiftNext  = 10'd0;
                end else begin
                    wdNext = wdCnt - WD_ONE;
                end
            end
            default: begin
                stateNext  = IDLE;
                bitCntNext = 4'd0;
                shiftNext  = 10'd0;
            end
        endcase
    end

    // Scan-code to key-bit map; the ext flag selects arrows vs. WASD
    always_comb begin
        keyHit = 1'b0;
        keyIdx = 3'd0;
        if (extFlag) begin
            case (oCode)
                8'h74: begin keyHit = 1'b1; keyIdx = 3'd0; end
                8'h6B: begin keyHit = 1'b1; keyIdx = 3'd1; end
                8'h72: begin keyHit = 1'b1; keyIdx = 3'd2; end
                8'h75: begin keyHit = 1'b1; keyIdx = 3'd3; end
                default: ;
            endcase
        end else begin
            case (oCode)
                8'h23: begin keyHit = 1'b1; keyIdx = 3'd4; end
                8'h1C: begin keyHit = 1'b1; keyIdx = 3'd5; end
                8'h1B: begin keyHit = 1'b1; keyIdx = 3'd6; end
                8'h1D: begin keyHit = 1'b1; keyIdx = 3'd7; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
            oKEY    <= 8'h00;
        end else if (frameBad) begin
            // A corrupted byte may have been a prefix; drop any pending one
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
        end else if (oCode_valid) begin
            if (oCode == 8'hE0) begin
                extFlag <= 1'b1;
            end else if (oCode == 8'hF0) begin
                brkFlag <= 1'b1;
            end else begin
                if (keyHit) begin
                    oKEY[keyIdx] <= ~brkFlag;
                end
                extFlag <= 1'b0;
                brkFlag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_scanner.sv
// tb_ps2_key_scanner
//   Directed bench for ps2_key_scanner: drives PS/2 frames bit by bit and
//   compares oKEY / oCode / pulse counts against hand-computed values.

module tb_ps2_key_scanner;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 30;

    logic       iCLK_50;
    logic       reset_n;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] oKEY;
    logic [7:0] oCode;
    logic       oCode_valid;
    logic       oErr;

    int testsRun    = 0;
    int testsFailed = 0;

    int validCnt = 0;
    int errCnt   = 0;
    int bothCnt  = 0;
    int validRises = 0;
    int errRises   = 0;
    logic validPrev = 1'b0;
    logic errPrev   = 1'b0;

    ps2_key_scanner #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (iCLK_50),
        .reset_n     (reset_n),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .oKEY        (oKEY),
        .oCode       (oCode),
        .oCode_valid (oCode_valid),
        .oErr        (oErr)
    );

    initial iCLK_50 = 1'b0;
    always #20 iCLK_50 = ~iCLK_50;

    // Pulse monitor, sampled away from the active edge
    always @(negedge iCLK_50) begin
        if (oCode_valid) validCnt++;
        if (oErr) errCnt++;
        if (oCode_valid && oErr) bothCnt++;
        if (oCode_valid && !validPrev) validRises++;
        if (oErr && !errPrev) errRises++;
        validPrev = oCode_valid;
        errPrev   = oErr;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(posedge iCLK_50); #2;
        PS2_DAT = b;
        repeat (HALF) @(posedge iCLK_50);
        #2 PS2_CLK = 1'b0;
        repeat (HALF) @(posedge iCLK_50);
        #2 PS2_CLK = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] code, input logic badPar, input logic stopBit);
        logic par;
        par = ~(^code) ^ badPar;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit(par);
        sendBit(stopBit);
        PS2_DAT = 1'b1;
        repeat (HALF) @(posedge iCLK_50);
    endtask

    task automatic sendByte(input logic [7:0] code);
        sendFrame(code, 1'b0, 1'b1);
    endtask

    int v0, e0;

    initial begin
        reset_n = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (5) @(posedge iCLK_50);
        @(negedge iCLK_50);
        checkVal("rst_key",   {24'd0, oKEY}, 32'h00);
        checkVal("rst_code",  {24'd0, oCode}, 32'h00);
        checkVal("rst_valid", {31'd0, oCode_valid}, 32'd0);
        checkVal("rst_err",   {31'd0, oErr}, 32'd0);
        #3 reset_n = 1'b1;
        repeat (10) @(posedge iCLK_50);

        // Arrow make/break
        v0 = validCnt;
        sendByte(8'hE0); sendByte(8'h75);
        checkVal("up1_make", {24'd0, oKEY}, 32'h08);
        checkVal("up1_code", {24'd0, oCode}, 32'h75);
        checkVal("up1_vcnt", validCnt - v0, 32'd2);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        checkVal("up1_break", {24'd0, oKEY}, 32'h00);

        // Two players
        sendByte(8'h1D);
        checkVal("p_seq0", {24'd0, oKEY}, 32'h80);
        sendByte(8'hE0); sendByte(8'h6B);
        checkVal("p_seq1", {24'd0, oKEY}, 32'h82);
        sendByte(8'h23);
        checkVal("p_seq2", {24'd0, oKEY}, 32'h92);
        sendByte(8'hF0); sendByte(8'h1D);
        checkVal("p_seq3", {24'd0, oKEY}, 32'h12);
        sendByte(8'hF0); sendByte(8'h23);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
        checkVal("p_clear", {24'd0, oKEY}, 32'h00);

        // Parity error
        v0 = validCnt; e0 = errCnt;
        sendFrame(8'h1D, 1'b1, 1'b1);
        checkVal("par_err",   errCnt - e0, 32'd1);
        checkVal("par_valid", validCnt - v0, 32'd0);
        checkVal("par_key",   {24'd0, oKEY}, 32'h00);
        checkVal("par_code",  {24'd0, oCode}, 32'h6B);
        sendByte(8'h1D);
        checkVal("par_next", {24'd0, oKEY}, 32'h80);
        // Error after F0 must drop the break prefix: next 1D is a make
        sendByte(8'hF0);
        sendFrame(8'h42, 1'b1, 1'b1);
        sendByte(8'h1D);
        checkVal("err_clr_brk", {24'd0, oKEY}, 32'h80);
        sendByte(8'hF0); sendByte(8'h1D);
        checkVal("w_break", {24'd0, oKEY}, 32'h00);

        // Stop-bit error
        v0 = validCnt; e0 = errCnt;
        sendFrame(8'h1C, 1'b0, 1'b0);
        checkVal("stop_err",   errCnt - e0, 32'd1);
        checkVal("stop_valid", validCnt - v0, 32'd0);
        checkVal("stop_key",   {24'd0, oKEY}, 32'h00);

        // Timeout after start + 4 data bits
        v0 = validCnt; e0 = errCnt;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        PS2_DAT = 1'b1;
        repeat (TIMEOUT + 10) @(posedge iCLK_50);
        checkVal("to_err",   errCnt - e0, 32'd1);
        checkVal("to_valid", validCnt - v0, 32'd0);
        sendByte(8'h1C);
        checkVal("to_next", {24'd0, oKEY}, 32'h20);
        sendByte(8'hF0); sendByte(8'h1C);
        checkVal("a_break", {24'd0, oKEY}, 32'h00);

        // Ignored codes
        v0 = validCnt;
        sendByte(8'h75);
        sendByte(8'hE0); sendByte(8'h1D);
        sendByte(8'h29);
        checkVal("ign_key",   {24'd0, oKEY}, 32'h00);
        checkVal("ign_valid", validCnt - v0, 32'd4);
        checkVal("ign_code",  {24'd0, oCode}, 32'h29);

        // Typematic, stray break, opposite directions
        sendByte(8'h1B); sendByte(8'h1B);
        checkVal("typematic", {24'd0, oKEY}, 32'h40);
        sendByte(8'hF0); sendByte(8'h23);
        checkVal("stray_brk", {24'd0, oKEY}, 32'h40);
        sendByte(8'hE0); sendByte(8'h74);
        sendByte(8'hE0); sendByte(8'h6B);
        checkVal("opposite", {24'd0, oKEY}, 32'h43);
        sendByte(8'hF0); sendByte(8'h1B);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
        checkVal("opp_rel", {24'd0, oKEY}, 32'h02);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);

        // Reset mid-frame
        sendByte(8'hE0); sendByte(8'h75);
        checkVal("mid_pre", {24'd0, oKEY}, 32'h08);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b0);
        PS2_DAT = 1'b1;
        @(posedge iCLK_50); #7;
        reset_n = 1'b0;
        #1;
        checkVal("mid_rst_key",  {24'd0, oKEY}, 32'h00);
        checkVal("mid_rst_code", {24'd0, oCode}, 32'h00);
        repeat (3) @(posedge iCLK_50);
        #3 reset_n = 1'b1;
        repeat (10) @(posedge iCLK_50);
        sendByte(8'hE0); sendByte(8'h72);
        checkVal("mid_after", {24'd0, oKEY}, 32'h04);

        // Pulse shape over the whole run
        @(negedge iCLK_50);
        checkVal("both_pulse",  bothCnt, 32'd0);
        checkVal("valid_width", validCnt, validRises);
        checkVal("err_width",   errCnt, errRises);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
